track_sequencer: RTL and testbench

Playback controller for the MP3 player. It arbitrates track-change requests from the front-panel PREV/NEXT buttons, the Bluetooth command decoder and the decoder's end-of-track flag. It owns the current track index and play/pause/stop state. It sequences the MP3 decoder front-end through a LOAD_REQ/LOAD_ACK handshake whenever a new track must be opened.

---
 rtl/track_sequencer_if.sv | 30 +++
 rtl/track_sequencer.sv | 155 +++++++++++++++
 tb/tb_track_sequencer.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/track_sequencer_if.sv
// Playback-controller bus: front-panel buttons, Bluetooth command channel,
// decoder load handshake and the player status outputs.
interface track_sequencer_if #(
  parameter int IDX_W = 3
);
  logic             BTN_PREV;
  logic             BTN_NEXT;
  logic             BT_VALID;
  logic [2:0]       BT_CMD;
  logic [IDX_W-1:0] BT_ARG;
  logic             BT_READY;
  logic             TRACK_END;
  logic             LOAD_REQ;
  logic             LOAD_ACK;
  logic [IDX_W-1:0] TRACK_IDX;
  logic             PLAYING;
  logic [1:0]       MODE;

  // Environment side: buttons, BT host, decoder.
  modport master (
    output BTN_PREV, BTN_NEXT, BT_VALID, BT_CMD, BT_ARG, TRACK_END, LOAD_ACK,
    input  BT_READY, LOAD_REQ, TRACK_IDX, PLAYING, MODE
  );

  // Sequencer side.
  modport slave (
    input  BTN_PREV, BTN_NEXT, BT_VALID, BT_CMD, BT_ARG, TRACK_END, LOAD_ACK,
    output BT_READY, LOAD_REQ, TRACK_IDX, PLAYING, MODE
  );
endinterface

// File: rtl/track_sequencer.sv
// Track sequencer: arbitrates BT commands, buttons and end-of-track, owns the
// track index and transport state, and drives the decoder load handshake.
module track_sequencer #(
  parameter int TRACK_NUM = 8,
  parameter int IDX_W     = 3,
  parameter int HOLDOFF   = 50000
) (
  input logic              CLK,
  input logic              RST,
  track_sequencer_if.slave bus
);
  // +2 keeps the counter at least one bit wide even when HOLDOFF is 0.
  localparam int CNT_W = $clog2(HOLDOFF + 2);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLDOFF);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TRACK_NUM - 1);
  localparam logic [IDX_W:0]   NUM_EXT  = (IDX_W + 1)'(TRACK_NUM);
  localparam logic [8:0]       NUM_9    = 9'(TRACK_NUM);

  localparam logic [2:0] C_PLAY  = 3'd1;
  localparam logic [2:0] C_PAUSE = 3'd2;
  localparam logic [2:0] C_NEXT  = 3'd3;
  localparam logic [2:0] C_PREV  = 3'd4;
  localparam logic [2:0] C_SEL   = 3'd5;
  localparam logic [2:0] C_MODE  = 3'd6;
  localparam logic [2:0] C_STOP  = 3'd7;

  typedef enum logic [1:0] {S_STOP, S_LOAD, S_PLAY, S_PAUSE} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [1:0]       mode;
  logic             load_req;
  logic             playing;
  logic [CNT_W-1:0] hold_cnt;
  logic [7:0]       lfsr;

  logic             bt_fire, btn_fire, end_fire;
  logic [IDX_W+1:0] arg_ext;
  logic [IDX_W-1:0] prev_idx, next_idx, pick_raw, shuf_idx, adv_idx;
  logic             chg, go_play, go_pause, go_stop, set_mode;
  logic [IDX_W-1:0] chg_idx;

  assign bus.BT_READY  = (state != S_LOAD);
  assign bus.LOAD_REQ  = load_req;
  assign bus.PLAYING   = playing;
  assign bus.TRACK_IDX = idx;
  assign bus.MODE      = mode;

  // Event arbitration and next-index candidates; lower-priority events are dropped.
  always_comb begin
    arg_ext  = {2'b00, bus.BT_ARG};
    bt_fire  = bus.BT_VALID && (state != S_LOAD);
    btn_fire = !bt_fire && (hold_cnt == '0) && (state != S_LOAD) &&
               (bus.BTN_PREV || bus.BTN_NEXT);
    end_fire = !bt_fire && !btn_fire && bus.TRACK_END && (state == S_PLAY);

    prev_idx = (idx == '0) ? LAST_IDX : idx - IDX_W'(1);
    next_idx = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
    pick_raw = IDX_W'({1'b0, lfsr} % NUM_9);
    shuf_idx = (pick_raw == idx) ? next_idx : pick_raw;
    adv_idx  = (mode == 2'd2) ? shuf_idx : next_idx;

    chg      = 1'b0;
    chg_idx  = idx;
    go_play  = 1'b0;
    go_pause = 1'b0;
    go_stop  = 1'b0;
    set_mode = 1'b0;

    if (bt_fire) begin
      case (bus.BT_CMD)
        C_PLAY:  go_play  = 1'b1;
        C_PAUSE: go_pause = 1'b1;
        C_STOP:  go_stop  = 1'b1;
        C_NEXT:  begin chg = 1'b1; chg_idx = adv_idx;  end
        C_PREV:  begin chg = 1'b1; chg_idx = prev_idx; end
        C_SEL:   if ({1'b0, bus.BT_ARG} < NUM_EXT) begin
                   chg = 1'b1; chg_idx = bus.BT_ARG;
                 end
        C_MODE:  set_mode = (arg_ext[1:0] != 2'd3);
        default: ;
      endcase
    end else if (btn_fire) begin
      chg     = 1'b1;
      chg_idx = bus.BTN_PREV ? prev_idx : adv_idx;
    end else if (end_fire) begin
      chg = 1'b1;
      case (mode)
        2'd1:    chg_idx = idx;
        2'd2:    chg_idx = shuf_idx;
        default: chg_idx = next_idx;
      endcase
    end
  end

  // Transport FSM with registered status outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_STOP;
      idx      <= '0;
      mode     <= 2'd0;
      load_req <= 1'b0;
      playing  <= 1'b0;
    end else begin
      if (set_mode) mode <= arg_ext[1:0];
      case (state)
        S_STOP: begin
          if (chg) idx <= chg_idx;
          else if (go_play) begin
            state    <= S_LOAD;
            load_req <= 1'b1;
          end
        end
        S_PLAY, S_PAUSE: begin
          if (chg) begin
            idx      <= chg_idx;
            state    <= S_LOAD;
            load_req <= 1'b1;
            playing  <= 1'b0;
          end else if (go_stop) begin
            state   <= S_STOP;
            playing <= 1'b0;
          end else if (go_pause && state == S_PLAY) begin
            state   <= S_PAUSE;
            playing <= 1'b0;
          end else if (go_play && state == S_PAUSE) begin
            state   <= S_PLAY;
            playing <= 1'b1;
          end
        end
        S_LOAD: begin
          if (bus.LOAD_ACK) begin
            state    <= S_PLAY;
            load_req <= 1'b0;
            playing  <= 1'b1;
          end
        end
        default: state <= S_STOP;
      endcase
    end
  end

  // Button lock-out: reload on an accepted button, otherwise count down to 0.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) hold_cnt <= '0;
    else if (btn_fire) hold_cnt <= HOLD_LD;
    else if (hold_cnt != '0) hold_cnt <= hold_cnt - CNT_W'(1);
  end

  // Free-running shuffle source, x^8+x^6+x^5+x^4 Fibonacci LFSR.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) lfsr <= 8'h01;
    else lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end
endmodule

// File: tb/tb_track_sequencer.sv
// Bench for track_sequencer: directed scenarios plus randomized traffic checked
// against a rule-level playback model.
module tb_track_sequencer;
  localparam int N  = 8;
  localparam int HO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  track_sequencer_if #(.IDX_W(3)) ifc0 ();
  track_sequencer_if #(.IDX_W(4)) ifc1 ();

  track_sequencer #(.TRACK_NUM(8), .IDX_W(3), .HOLDOFF(HO)) dut0 (
    .CLK(clk), .RST(rst), .bus(ifc0)
  );
  track_sequencer #(.TRACK_NUM(6), .IDX_W(4), .HOLDOFF(HO)) dut1 (
    .CLK(clk), .RST(rst), .bus(ifc1)
  );

  // Reference model of the player (DUT0 only).
  typedef enum {M_STOPPED, M_LOADING, M_PLAYING, M_PAUSED} mst_t;
  mst_t       m_st;
  int         m_idx, m_mode, m_hold;
  logic [7:0] m_lfsr;

  function automatic int nxt(input int i); return (i == N - 1) ? 0 : i + 1; endfunction
  function automatic int prv(input int i); return (i == 0) ? N - 1 : i - 1; endfunction

  task automatic m_reset();
    m_st = M_STOPPED; m_idx = 0; m_mode = 0; m_hold = 0; m_lfsr = 8'h01;
  endtask

  // Apply the inputs currently driven on ifc0 for one clock.
  task automatic model_step();
    int pick, tgt, a;
    bit bt_acc, btn_acc, chg;
    pick = int'(m_lfsr) % N;
    if (pick == m_idx) pick = nxt(m_idx);
    a = int'(ifc0.BT_ARG);
    bt_acc  = ifc0.BT_VALID && (m_st != M_LOADING);
    btn_acc = !bt_acc && (m_hold == 0) && (m_st != M_LOADING) && (ifc0.BTN_PREV || ifc0.BTN_NEXT);
    if (btn_acc) m_hold = HO; else if (m_hold > 0) m_hold--;
    chg = 0; tgt = m_idx;
    if (m_st == M_LOADING) begin
      if (ifc0.LOAD_ACK) m_st = M_PLAYING;
    end else if (bt_acc) begin
      case (int'(ifc0.BT_CMD))
        1: if (m_st == M_STOPPED) m_st = M_LOADING; else if (m_st == M_PAUSED) m_st = M_PLAYING;
        2: if (m_st == M_PLAYING) m_st = M_PAUSED;
        3: begin chg = 1; tgt = (m_mode == 2) ? pick : nxt(m_idx); end
        4: begin chg = 1; tgt = prv(m_idx); end
        5: if (a < N) begin chg = 1; tgt = a; end
        6: if ((a % 4) != 3) m_mode = a % 4;
        7: m_st = M_STOPPED;
        default: ;
      endcase
    end else if (btn_acc) begin
      chg = 1;
      tgt = ifc0.BTN_PREV ? prv(m_idx) : ((m_mode == 2) ? pick : nxt(m_idx));
    end else if (ifc0.TRACK_END && m_st == M_PLAYING) begin
      chg = 1;
      tgt = (m_mode == 1) ? m_idx : ((m_mode == 2) ? pick : nxt(m_idx));
    end
    if (chg) begin
      m_idx = tgt;
      if (m_st != M_STOPPED) m_st = M_LOADING;
    end
    m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  endtask

  // One clock: model consumes the inputs, DUT samples them, outputs read 1 unit later.
  task automatic step();
    model_step();
    @(posedge clk); #1;
  endtask

  task automatic clear_inputs();
    ifc0.BTN_PREV = 0; ifc0.BTN_NEXT = 0; ifc0.BT_VALID = 0; ifc0.BT_CMD = 0;
    ifc0.BT_ARG = 0; ifc0.TRACK_END = 0; ifc0.LOAD_ACK = 0;
    ifc1.BTN_PREV = 0; ifc1.BTN_NEXT = 0; ifc1.BT_VALID = 0; ifc1.BT_CMD = 0;
    ifc1.BT_ARG = 0; ifc1.TRACK_END = 0; ifc1.LOAD_ACK = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    m_reset();
    rst = 0;
  endtask

  task automatic bt0(input logic [2:0] c, input int a);
    ifc0.BT_VALID = 1; ifc0.BT_CMD = c; ifc0.BT_ARG = 3'(a);
    step();
    ifc0.BT_VALID = 0; ifc0.BT_CMD = 0; ifc0.BT_ARG = 0;
  endtask

  task automatic ack0();
    ifc0.LOAD_ACK = 1; step(); ifc0.LOAD_ACK = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (ifc0.TRACK_IDX !== 3'd0) begin bad++; $display("FAIL reset_idx got=%0d exp=0", ifc0.TRACK_IDX); end
    total++; if (ifc0.MODE !== 2'd0) begin bad++; $display("FAIL reset_mode got=%0d exp=0", ifc0.MODE); end
    total++; if (ifc0.LOAD_REQ !== 1'b0) begin bad++; $display("FAIL reset_load_req got=%b exp=0", ifc0.LOAD_REQ); end
    total++; if (ifc0.PLAYING !== 1'b0) begin bad++; $display("FAIL reset_playing got=%b exp=0", ifc0.PLAYING); end
    total++; if (ifc0.BT_READY !== 1'b1) begin bad++; $display("FAIL reset_bt_ready got=%b exp=1", ifc0.BT_READY); end
    m_reset();
    rst = 0;
  endtask

  task automatic test_load_handshake();
    do_reset();
    bt0(3'd1, 0);
    total++; if (ifc0.LOAD_REQ !== 1'b1) begin bad++; $display("FAIL load_req_rise got=%b exp=1", ifc0.LOAD_REQ); end
    total++; if (ifc0.TRACK_IDX !== 3'd0) begin bad++; $display("FAIL load_idx got=%0d exp=0", ifc0.TRACK_IDX); end
    total++; if (ifc0.BT_READY !== 1'b0) begin bad++; $display("FAIL load_bt_ready got=%b exp=0", ifc0.BT_READY); end
    repeat (2) begin
      step();
      total++; if (ifc0.LOAD_REQ !== 1'b1) begin bad++; $display("FAIL load_hold got=%b exp=1", ifc0.LOAD_REQ); end
    end
    ack0();
    total++; if (ifc0.LOAD_REQ !== 1'b0) begin bad++; $display("FAIL ack_load_req got=%b exp=0", ifc0.LOAD_REQ); end
    total++; if (ifc0.PLAYING !== 1'b1) begin bad++; $display("FAIL ack_playing got=%b exp=1", ifc0.PLAYING); end
    bt0(3'd7, 0);
    total++; if (ifc0.PLAYING !== 1'b0) begin bad++; $display("FAIL stop_playing got=%b exp=0", ifc0.PLAYING); end
    bt0(3'd1, 0);
    total++; if (ifc0.LOAD_REQ !== 1'b1) begin bad++; $display("FAIL reload_req got=%b exp=1", ifc0.LOAD_REQ); end
    #2 rst = 1;
    #1;
    total++; if (ifc0.LOAD_REQ !== 1'b0) begin bad++; $display("FAIL async_rst_load_req got=%b exp=0", ifc0.LOAD_REQ); end
    total++; if (ifc0.BT_READY !== 1'b1) begin bad++; $display("FAIL async_rst_bt_ready got=%b exp=1", ifc0.BT_READY); end
    do_reset();
  endtask

  task automatic test_wrap();
    do_reset();
    ifc0.BTN_PREV = 1; step(); ifc0.BTN_PREV = 0;
    total++; if (ifc0.TRACK_IDX !== 3'd7) begin bad++; $display("FAIL prev_wrap_idx got=%0d exp=7", ifc0.TRACK_IDX); end
    total++; if (ifc0.LOAD_REQ !== 1'b0 || ifc0.PLAYING !== 1'b0) begin bad++; $display("FAIL prev_stays_stop got=%b%b exp=00", ifc0.LOAD_REQ, ifc0.PLAYING); end
    bt0(3'd1, 0);
    ack0();
    ifc0.TRACK_END = 1; step(); ifc0.TRACK_END = 0;
    total++; if (ifc0.TRACK_IDX !== 3'd0) begin bad++; $display("FAIL end_wrap_idx got=%0d exp=0", ifc0.TRACK_IDX); end
    total++; if (ifc0.LOAD_REQ !== 1'b1) begin bad++; $display("FAIL end_wrap_load got=%b exp=1", ifc0.LOAD_REQ); end
    ack0();
  endtask

  task automatic test_holdoff();
    int exp_a [6] = '{1, 1, 1, 1, 1, 2};
    int exp_b [3] = '{1, 1, 2};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      ifc0.BTN_NEXT = (c == 0 || c == 2 || c == 5);
      step();
      total++; if (int'(ifc0.TRACK_IDX) !== exp_a[c]) begin bad++; $display("FAIL holdoff_btn c=%0d got=%0d exp=%0d", c, ifc0.TRACK_IDX, exp_a[c]); end
    end
    ifc0.BTN_NEXT = 0;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      ifc0.BTN_NEXT = (c == 0);
      ifc0.BT_VALID = (c == 2); ifc0.BT_CMD = 3'd3;
      step();
      total++; if (int'(ifc0.TRACK_IDX) !== exp_b[c]) begin bad++; $display("FAIL holdoff_bt c=%0d got=%0d exp=%0d", c, ifc0.TRACK_IDX, exp_b[c]); end
    end
    clear_inputs();
  endtask

  task automatic test_priority();
    do_reset();
    bt0(3'd1, 0);
    ack0();
    ifc0.BTN_NEXT = 1; ifc0.TRACK_END = 1;
    bt0(3'd5, 5);
    ifc0.BTN_NEXT = 0; ifc0.TRACK_END = 0;
    total++; if (ifc0.TRACK_IDX !== 3'd5) begin bad++; $display("FAIL prio_idx got=%0d exp=5", ifc0.TRACK_IDX); end
    total++; if (ifc0.LOAD_REQ !== 1'b1) begin bad++; $display("FAIL prio_load got=%b exp=1", ifc0.LOAD_REQ); end
    ack0();
    ifc0.BTN_NEXT = 1; step(); ifc0.BTN_NEXT = 0;
    total++; if (ifc0.TRACK_IDX !== 3'd6) begin bad++; $display("FAIL prio_no_holdoff got=%0d exp=6", ifc0.TRACK_IDX); end
    ack0();
    // Six-track instance: out-of-range SELECT still wins arbitration.
    do_reset();
    ifc1.BT_VALID = 1; ifc1.BT_CMD = 3'd1; step(); ifc1.BT_VALID = 0;
    ifc1.LOAD_ACK = 1; step(); ifc1.LOAD_ACK = 0;
    total++; if (ifc1.PLAYING !== 1'b1) begin bad++; $display("FAIL n6_playing got=%b exp=1", ifc1.PLAYING); end
    ifc1.BT_VALID = 1; ifc1.BT_CMD = 3'd5; ifc1.BT_ARG = 4'd9; ifc1.BTN_NEXT = 1; ifc1.TRACK_END = 1;
    step();
    clear_inputs();
    total++; if (ifc1.TRACK_IDX !== 4'd0) begin bad++; $display("FAIL n6_sel_idx got=%0d exp=0", ifc1.TRACK_IDX); end
    total++; if (ifc1.LOAD_REQ !== 1'b0 || ifc1.PLAYING !== 1'b1) begin bad++; $display("FAIL n6_sel_state got=%b%b exp=01", ifc1.LOAD_REQ, ifc1.PLAYING); end
    step();
    total++; if (ifc1.TRACK_IDX !== 4'd0) begin bad++; $display("FAIL n6_btn_dropped got=%0d exp=0", ifc1.TRACK_IDX); end
  endtask

  task automatic test_repeat_shuffle();
    logic [7:0] seen;
    int prev;
    do_reset();
    bt0(3'd6, 1);
    total++; if (ifc0.MODE !== 2'd1) begin bad++; $display("FAIL mode_set got=%0d exp=1", ifc0.MODE); end
    bt0(3'd5, 3);
    bt0(3'd1, 0);
    ack0();
    ifc0.TRACK_END = 1; step(); ifc0.TRACK_END = 0;
    total++; if (ifc0.TRACK_IDX !== 3'd3 || ifc0.LOAD_REQ !== 1'b1) begin bad++; $display("FAIL repeat_one got=%0d/%b exp=3/1", ifc0.TRACK_IDX, ifc0.LOAD_REQ); end
    ack0();
    bt0(3'd6, 3);
    total++; if (ifc0.MODE !== 2'd1) begin bad++; $display("FAIL mode_arg3 got=%0d exp=1", ifc0.MODE); end
    bt0(3'd6, 2);
    seen = 8'h00;
    for (int e = 0; e < 200; e++) begin
      prev = int'(ifc0.TRACK_IDX);
      ifc0.TRACK_END = 1; step(); ifc0.TRACK_END = 0;
      total++; if (int'(ifc0.TRACK_IDX) !== m_idx || ifc0.LOAD_REQ !== 1'b1) begin bad++; $display("FAIL shuffle_pick e=%0d got=%0d exp=%0d", e, ifc0.TRACK_IDX, m_idx); end
      total++; if (int'(ifc0.TRACK_IDX) == prev) begin bad++; $display("FAIL shuffle_repeat e=%0d got=%0d prev=%0d", e, ifc0.TRACK_IDX, prev); end
      seen[ifc0.TRACK_IDX] = 1'b1;
      ack0();
    end
    total++; if (seen !== 8'hFF) begin bad++; $display("FAIL shuffle_cover got=%h exp=ff", seen); end
  endtask

  task automatic test_pause_resume();
    do_reset();
    bt0(3'd1, 0);
    ack0();
    bt0(3'd2, 0);
    total++; if (ifc0.PLAYING !== 1'b0 || ifc0.LOAD_REQ !== 1'b0) begin bad++; $display("FAIL pause got=%b%b exp=00", ifc0.PLAYING, ifc0.LOAD_REQ); end
    bt0(3'd1, 0);
    total++; if (ifc0.PLAYING !== 1'b1 || ifc0.LOAD_REQ !== 1'b0) begin bad++; $display("FAIL resume got=%b%b exp=10", ifc0.PLAYING, ifc0.LOAD_REQ); end
    bt0(3'd3, 0);
    total++; if (ifc0.TRACK_IDX !== 3'd1 || ifc0.LOAD_REQ !== 1'b1) begin bad++; $display("FAIL bt_next got=%0d/%b exp=1/1", ifc0.TRACK_IDX, ifc0.LOAD_REQ); end
    ifc0.BT_VALID = 1; ifc0.BT_CMD = 3'd2;
    repeat (2) begin
      step();
      total++; if (ifc0.BT_READY !== 1'b0 || ifc0.LOAD_REQ !== 1'b1) begin bad++; $display("FAIL load_busy got=%b%b exp=01", ifc0.BT_READY, ifc0.LOAD_REQ); end
    end
    ack0();
    total++; if (ifc0.PLAYING !== 1'b1 || ifc0.BT_READY !== 1'b1) begin bad++; $display("FAIL held_ack got=%b%b exp=11", ifc0.PLAYING, ifc0.BT_READY); end
    step();
    total++; if (ifc0.PLAYING !== 1'b0) begin bad++; $display("FAIL held_cmd got=%b exp=0", ifc0.PLAYING); end
    clear_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      ifc0.BT_VALID  = ($urandom_range(0, 3) == 0);
      ifc0.BT_CMD    = 3'($urandom_range(0, 7));
      ifc0.BT_ARG    = 3'($urandom_range(0, 7));
      ifc0.BTN_PREV  = ($urandom_range(0, 9) == 0);
      ifc0.BTN_NEXT  = ($urandom_range(0, 9) == 0);
      ifc0.TRACK_END = ($urandom_range(0, 9) == 0);
      ifc0.LOAD_ACK  = ($urandom_range(0, 4) < 2);
      step();
      total++; if (int'(ifc0.TRACK_IDX) !== m_idx) begin bad++; $display("FAIL rnd_idx c=%0d got=%0d exp=%0d", c, ifc0.TRACK_IDX, m_idx); end
      total++; if (int'(ifc0.MODE) !== m_mode) begin bad++; $display("FAIL rnd_mode c=%0d got=%0d exp=%0d", c, ifc0.MODE, m_mode); end
      total++; if (ifc0.LOAD_REQ !== (m_st == M_LOADING)) begin bad++; $display("FAIL rnd_load c=%0d got=%b exp=%b", c, ifc0.LOAD_REQ, m_st == M_LOADING); end
      total++; if (ifc0.PLAYING !== (m_st == M_PLAYING)) begin bad++; $display("FAIL rnd_play c=%0d got=%b exp=%b", c, ifc0.PLAYING, m_st == M_PLAYING); end
      total++; if (ifc0.BT_READY !== (m_st != M_LOADING)) begin bad++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, ifc0.BT_READY, m_st != M_LOADING); end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_load_handshake();
    test_wrap();
    test_holdoff();
    test_priority();
    test_repeat_shuffle();
    test_pause_resume();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
